ctr_record_buffer: RTL

//   Circular storage for Control Transfer Records produced by the CTR unit. Accepts up to

---
 rtl/ctr_record_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ctr_record_buffer.sv
// Circular buffer of Control Transfer Records. Up to NrCommitPorts records are
// appended per cycle in commit-port order; logical read index 0 is the newest.
// Holds the write pointer, the sticky freeze bit and the clear operation.

package ctr_record_buffer_pkg;
    // Encoded transfer kind (call, return, branch, ...), opaque to the buffer.
    typedef logic [3:0] ctr_type_t;
endpackage

module ctr_record_buffer
    import ctr_record_buffer_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned Depth         = 16,
    localparam int unsigned IdxW         = $clog2(Depth)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NrCommitPorts-1:0] rec_valid_i,
    input  logic [XLEN-1:0]          rec_source_i [NrCommitPorts],
    input  logic [XLEN-1:0]          rec_target_i [NrCommitPorts],
    input  ctr_type_t                rec_type_i   [NrCommitPorts],
    input  logic                     enable_i,
    input  logic                     freeze_i,
    input  logic                     clear_i,
    input  logic                     status_we_i,
    input  logic [IdxW-1:0]          status_wrptr_i,
    input  logic                     status_frozen_i,
    input  logic                     rd_req_i,
    input  logic [IdxW-1:0]          rd_idx_i,
    output logic [IdxW-1:0]          wrptr_o,
    output logic                     frozen_o,
    output logic                     rd_valid_o,
    output logic                     rd_entry_valid_o,
    output logic [XLEN-1:0]          rd_source_o,
    output logic [XLEN-1:0]          rd_target_o,
    output ctr_type_t                rd_type_o
);

    // Architectural state
    logic [IdxW-1:0]  wrptr_q, wrptr_d;
    logic             frozen_q, frozen_d;
    logic [Depth-1:0] valid_q, valid_d;

    // Payload storage
    logic [XLEN-1:0]  src_mem  [Depth];
    logic [XLEN-1:0]  tgt_mem  [Depth];
    ctr_type_t        type_mem [Depth];

    // Per-port write slot and enable
    logic [IdxW-1:0]          slot [NrCommitPorts];
    logic [NrCommitPorts-1:0] port_we;
    logic [IdxW-1:0]          push_cnt;
    logic                     push_en;

    // Read pipeline registers
    logic             rd_valid_q;
    logic             rd_entry_valid_q;
    logic [XLEN-1:0]  rd_source_q;
    logic [XLEN-1:0]  rd_target_q;
    ctr_type_t        rd_type_q;
    logic [IdxW-1:0]  rd_slot;

    // Pushes only land when recording is live and no CSR-level operation wins.
    assign push_en = enable_i && !frozen_q && !clear_i && !status_we_i;

    // Compact valid ports onto consecutive slots starting at the write pointer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        push_cnt = '0;
        port_we  = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            slot[p]    = wrptr_q + push_cnt;
            port_we[p] = push_en && rec_valid_i[p];
            push_cnt   = push_cnt + IdxW'(rec_valid_i[p]);
        end
    end

    // Next-state for pointer, freeze bit and valid bits; clear > status write > push.
    always_comb begin
        wrptr_d  = wrptr_q;
        frozen_d = frozen_q;
        valid_d  = valid_q;
        if (clear_i) begin
            wrptr_d = '0;
            valid_d = '0;
        end else if (status_we_i) begin
            wrptr_d = status_wrptr_i;
        end else if (push_en) begin
            wrptr_d = wrptr_q + push_cnt;
            for (int p = 0; p < NrCommitPorts; p++) begin
                if (port_we[p]) valid_d[slot[p]] = 1'b1;
            end
        end
        // A CSR status write overrides a same-cycle freeze request.
        if (status_we_i) begin
            frozen_d = status_frozen_i;
        end else if (freeze_i) begin
            frozen_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn_i) begin
            wrptr_q  <= '0;
            frozen_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            wrptr_q  <= wrptr_d;
            frozen_q <= frozen_d;
            valid_q  <= valid_d;
        end
    end

    // Payload write; slots of one cycle are distinct since Depth >= NrCommitPorts.
    always_ff @(posedge clk_i) begin
        // NOTE: the payload RAM has no reset; the valid bits alone decide whether an entry is meaningful.
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (port_we[p]) begin
                src_mem[slot[p]]  <= rec_source_i[p];
                tgt_mem[slot[p]]  <= rec_target_i[p];
                type_mem[slot[p]] <= rec_type_i[p];
            end
        end
    end

    // Logical index 0 is the slot just behind the write pointer.
    assign rd_slot = IdxW'(wrptr_q - IdxW'(1) - rd_idx_i);

    // One-cycle read; data holds between requests and is zero for empty slots.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_valid_q       <= 1'b0;
            rd_entry_valid_q <= 1'b0;
            rd_source_q      <= '0;
            rd_target_q      <= '0;
            rd_type_q        <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_entry_valid_q <= valid_q[rd_slot];
                rd_source_q      <= valid_q[rd_slot] ? src_mem[rd_slot]  : '0;
                rd_target_q      <= valid_q[rd_slot] ? tgt_mem[rd_slot]  : '0;
                rd_type_q        <= valid_q[rd_slot] ? type_mem[rd_slot] : '0;
            end
        end
    end

    assign wrptr_o          = wrptr_q;
    assign frozen_o         = frozen_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_entry_valid_o = rd_entry_valid_q;
    assign rd_source_o      = rd_source_q;
    assign rd_target_o      = rd_target_q;
    assign rd_type_o        = rd_type_q;

endmodule
